// File: rtl/fifo_frame_streamer.sv
// fifo_frame_streamer: pops ADC frames and serializes the enabled 16-bit channel words MSB first on SDO.
// Define FIFO_STREAMER_PARITY_EN to append an even-parity bit after every transmitted word.
module fifo_frame_streamer #(
  parameter int NCH = 8,
  parameter int WORD_W = 16,
  parameter int CNT_W = 8
) (
  input  logic                  SCK,
  input  logic                  NRST_sync,
  input  logic                  STREAM_EN,
  input  logic [NCH-1:0]        CHMASK,
  input  logic [NCH*WORD_W-1:0] ADC_data,
  output logic                  FIFO_POP,
  output logic                  SDO,
  output logic                  SDO_VALID,
  output logic                  FRAME_END,
  output logic [CNT_W-1:0]      FRAME_CNT
);
`ifdef FIFO_STREAMER_PARITY_EN
  localparam int L = WORD_W + 1;
`else
  localparam int L = WORD_W;
`endif
  localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int POS_W = $clog2(L + 1);
  typedef enum logic [1:0] {IDLE, POP, CAPT, SHIFT} state_t;
  state_t                r_state, w_state;
  logic [NCH*WORD_W-1:0] r_shreg, w_src;
  logic [NCH-1:0]        r_mask, w_cap_mask;
  logic [CH_W-1:0]       r_ch, w_ch, w_cap_lo, w_nxt_ch, w_hi;
  logic [POS_W-1:0]      r_pos, w_pos;
  logic [WORD_W-1:0]     w_word, w_shl;
  logic                  w_word_done, w_frame_done, w_sdo, w_end;
  logic                  r_pop, r_sdo, r_sdo_valid, r_frame_end;
  logic [CNT_W-1:0]      r_cnt;
  assign FIFO_POP  = r_pop;
  assign SDO       = r_sdo;
  assign SDO_VALID = r_sdo_valid;
  assign FRAME_END = r_frame_end;
  assign FRAME_CNT = r_cnt;
  // Channel search: lowest enabled at capture, next enabled above r_ch, highest enabled in the latched mask.
  always_comb begin
    w_cap_mask = (CHMASK == '0) ? '1 : CHMASK;
    w_cap_lo = '0;
    w_nxt_ch = '0;
    w_hi = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (w_cap_mask[i]) w_cap_lo = CH_W'(i);
      if (r_mask[i] && CH_W'(i) > r_ch) w_nxt_ch = CH_W'(i);
    end
    for (int i = 0; i < NCH; i++)
      if (r_mask[i]) w_hi = CH_W'(i);
  end
  // Outputs are registered, so this block computes what the next cycle presents.
  always_comb begin
    w_state = r_state;
    w_ch = r_ch;
    w_pos = r_pos;
    w_word_done = (int'(r_pos) == L - 1);
    w_frame_done = w_word_done && (r_ch == w_hi);
    case (r_state)
      IDLE: w_state = POP;
      POP: w_state = CAPT;
      CAPT: begin
        w_state = SHIFT;
        w_ch = w_cap_lo;
        w_pos = '0;
      end
      default: begin
        w_state = w_frame_done ? POP : SHIFT;
        w_ch = w_word_done ? w_nxt_ch : r_ch;
        w_pos = w_word_done ? '0 : r_pos + 1'b1;
      end
    endcase
    if (!STREAM_EN) w_state = IDLE;
    w_src = (r_state == CAPT) ? ADC_data : r_shreg;
    w_word = w_src[int'(w_ch)*WORD_W +: WORD_W];
    w_shl = w_word << w_pos;
    w_sdo = (int'(w_pos) >= WORD_W) ? ^w_word : w_shl[WORD_W-1];
    w_end = (w_state == SHIFT) && (int'(w_pos) == L - 1) && (w_ch == w_hi);
  end
  always_ff @(posedge SCK or negedge NRST_sync) begin
    if (!NRST_sync) begin
      r_state <= IDLE;
      r_shreg <= '0;
      r_mask <= '0;
      r_ch <= '0;
      r_pos <= '0;
      r_pop <= 1'b0;
      r_sdo <= 1'b0;
      r_sdo_valid <= 1'b0;
      r_frame_end <= 1'b0;
      r_cnt <= '0;
    end else begin
      r_state <= w_state;
      r_ch <= w_ch;
      r_pos <= w_pos;
      if (r_state == CAPT) begin
        r_shreg <= ADC_data;
        r_mask <= w_cap_mask;
      end
      r_pop <= (w_state == POP);
      r_sdo_valid <= (w_state == SHIFT);
      r_sdo <= (w_state == SHIFT) && w_sdo;
      r_frame_end <= w_end;
      if (r_state == IDLE && w_state == POP) r_cnt <= '0;
      else if (r_state == SHIFT && w_frame_done && r_cnt != '1) r_cnt <= r_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_fifo_frame_streamer.sv
`timescale 1ns/1ps
// tb_fifo_frame_streamer: FIFO model feeds frames; expected bits are queued at capture and
// a negedge monitor compares every SDO cycle against them.
module tb_fifo_frame_streamer;
`ifdef FIFO_STREAMER_PARITY_EN
  localparam int L = 17;
  localparam bit PAR = 1'b1;
`else
  localparam int L = 16;
  localparam bit PAR = 1'b0;
`endif
  logic         SCK = 1'b0;
  logic         NRST_sync = 1'b0;
  logic         STREAM_EN = 1'b0;
  logic [7:0]   CHMASK = 8'hFF;
  logic [127:0] ADC_data = '0;
  logic         FIFO_POP, SDO, SDO_VALID, FRAME_END;
  logic [7:0]   FRAME_CNT;
  logic [127:0] fifo_q[$];
  logic [1:0]   exp_q[$];
  logic [127:0] cap_f;
  logic [1:0]   m_e;
  logic         prev_pop = 1'b0;
  logic         cnt_due = 1'b0;
  int           n_chk = 0, n_pass = 0, e_cnt = 0;
  localparam logic [127:0] TP_FRAME = 128'h7777_6666_5555_4444_3333_2222_1111_8001;

  fifo_frame_streamer dut (
    .SCK(SCK), .NRST_sync(NRST_sync), .STREAM_EN(STREAM_EN), .CHMASK(CHMASK),
    .ADC_data(ADC_data), .FIFO_POP(FIFO_POP), .SDO(SDO), .SDO_VALID(SDO_VALID),
    .FRAME_END(FRAME_END), .FRAME_CNT(FRAME_CNT)
  );

  always #5 SCK = ~SCK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge SCK);
  endtask

  // Reference: enabled words in ascending channel order, MSB first, optional parity; last bit flags frame end.
  task automatic push_exp(input logic [127:0] f, input logic [7:0] m);
    logic [7:0] em;
    logic [15:0] w;
    int last;
    em = (m == 8'h00) ? 8'hFF : m;
    last = 0;
    for (int c = 0; c < 8; c++) if (em[c]) last = c;
    for (int c = 0; c < 8; c++) begin
      if (em[c]) begin
        w = f[c*16 +: 16];
        for (int b = 15; b >= 0; b--) exp_q.push_back({w[b], (c == last) && (b == 0) && !PAR});
        if (PAR) exp_q.push_back({^w, c == last});
      end
    end
  endtask

  // FIFO read port: data appears after the pop edge, valid for one cycle, then junk.
  initial forever begin
    @(posedge SCK);
    if (FIFO_POP) begin
      #1 ADC_data = (fifo_q.size() > 0) ? fifo_q.pop_front() : '0;
      cap_f = ADC_data;
      @(posedge SCK);
      #1 push_exp(cap_f, CHMASK);
      ADC_data = {$urandom, $urandom, $urandom, $urandom};
    end
  end

  initial forever begin
    @(negedge SCK);
    if (cnt_due) begin
      chk("frame_cnt", FRAME_CNT, e_cnt);
      cnt_due = 1'b0;
    end
    if (SDO_VALID) begin
      chk("bit_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        m_e = exp_q.pop_front();
        chk("sdo", SDO, m_e[1]);
        chk("frame_end", FRAME_END, m_e[0]);
        if (FRAME_END) begin
          e_cnt = (e_cnt == 255) ? 255 : e_cnt + 1;
          cnt_due = 1'b1;
        end
      end
    end else chk("idle_out", {SDO, FRAME_END}, 0);
    if (FIFO_POP) chk("pop_width", prev_pop, 0);
    prev_pop = FIFO_POP;
  end

  task automatic burst(input int n, input logic [7:0] m);
    int pops[$];
    int fe, cyc, k, nb, fe_cyc;
    logic pv;
    k = $countones((m == 8'h00) ? 8'hFF : m);
    fe = 0; cyc = 0; nb = 0; fe_cyc = 0; pv = 1'b0;
    CHMASK = m;
    e_cnt = 0;
    STREAM_EN = 1'b1;
    while (fe < n && cyc < n * (2 + 8 * L) + 20) begin
      @(negedge SCK);
      cyc++;
      if (FIFO_POP) pops.push_back(cyc);
      if (SDO_VALID && !pv) begin
        if (pops.size() > 0) chk("pop_to_bit", cyc - pops[$], 2);
        if (fe > 0) chk("gap", cyc - fe_cyc - 1, 2);
      end
      pv = SDO_VALID;
      if (SDO_VALID) nb++;
      if (FRAME_END) begin
        chk("frame_len", nb, k * L);
        nb = 0; fe++; fe_cyc = cyc;
      end
    end
    STREAM_EN = 1'b0;
    chk("burst_frames", fe, n);
    chk("burst_pops", pops.size(), n);
    for (int i = 1; i < pops.size(); i++) chk("pop_spacing", pops[i] - pops[i-1], 2 + k * L);
    tick(3);
    chk("burst_cnt", FRAME_CNT, (n > 255) ? 255 : n);
    chk("drained", exp_q.size(), 0);
  endtask

  initial begin
    int bits, fe, cyc;
    logic [7:0] m;
    int n;
    tick(2);
    chk("rst_pop", FIFO_POP, 0);
    chk("rst_sdo", SDO, 0);
    chk("rst_valid", SDO_VALID, 0);
    chk("rst_fe", FRAME_END, 0);
    chk("rst_cnt", FRAME_CNT, 0);
    NRST_sync = 1'b1;
    tick(2);
    chk("idle_no_pop", FIFO_POP, 0);
    fifo_q.push_back(TP_FRAME);
    burst(1, 8'hFF);
    fifo_q.push_back(TP_FRAME);
    burst(1, 8'h82);
    fifo_q.push_back(TP_FRAME);
    burst(1, 8'h00);
    repeat (3) fifo_q.push_back(TP_FRAME);
    burst(3, 8'hFF);
    for (int i = 0; i < 8; i++) begin
      m = 8'($urandom);
      n = $urandom_range(1, 3);
      for (int j = 0; j < n - (i % 2); j++) fifo_q.push_back({$urandom, $urandom, $urandom, $urandom});
      burst(n, m);
    end
    repeat (5) fifo_q.push_back({$urandom, $urandom, $urandom, $urandom});
    burst(300, 8'h01);
`ifdef FIFO_STREAMER_PARITY_EN
    fifo_q.push_back({112'h0, 16'h0001});
    burst(1, 8'h01);
    fifo_q.push_back({112'h0, 16'h0003});
    burst(1, 8'h01);
`endif
    // Abort at bit 40 of the third frame.
    repeat (3) fifo_q.push_back({$urandom, $urandom, $urandom, $urandom});
    CHMASK = 8'hFF; e_cnt = 0; STREAM_EN = 1'b1;
    bits = 0; fe = 0; cyc = 0;
    while (!(fe == 2 && bits == 40) && cyc < 1000) begin
      @(negedge SCK);
      cyc++;
      if (SDO_VALID) bits++;
      if (FRAME_END) begin fe++; bits = 0; end
    end
    chk("abort_reached", bits, 40);
    STREAM_EN = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge SCK);
      chk("abort_valid", SDO_VALID, 0);
      chk("abort_fe", FRAME_END, 0);
    end
    chk("abort_cnt", FRAME_CNT, 2);
    exp_q.delete();
    e_cnt = 0; STREAM_EN = 1'b1;
    @(negedge SCK);
    chk("reen_pop", FIFO_POP, 1);
    chk("reen_cnt", FRAME_CNT, 0);
    cyc = 0;
    while (!FRAME_END && cyc < 200) begin @(negedge SCK); cyc++; end
    chk("reen_frame_end", FRAME_END, 1);
    STREAM_EN = 1'b0;
    tick(3);
    chk("reen_cnt_done", FRAME_CNT, 1);
    // Asynchronous reset at bit 10.
    fifo_q.push_back({$urandom, $urandom, $urandom, $urandom});
    CHMASK = 8'hFF; e_cnt = 0; STREAM_EN = 1'b1;
    bits = 0; cyc = 0;
    while (bits < 10 && cyc < 100) begin
      @(negedge SCK);
      cyc++;
      if (SDO_VALID) bits++;
    end
    chk("rst_reached", bits, 10);
    #2 NRST_sync = 1'b0;
    #1;
    chk("arst_pop", FIFO_POP, 0);
    chk("arst_sdo", SDO, 0);
    chk("arst_valid", SDO_VALID, 0);
    chk("arst_fe", FRAME_END, 0);
    chk("arst_cnt", FRAME_CNT, 0);
    STREAM_EN = 1'b0;
    exp_q.delete();
    e_cnt = 0;
    @(negedge SCK);
    NRST_sync = 1'b1;
    tick(3);
    chk("post_rst_pop", FIFO_POP, 0);
    chk("post_rst_valid", SDO_VALID, 0);
    fifo_q.push_back(TP_FRAME);
    burst(1, 8'h0F);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
